regfile_wb_arbiter: RTL

Write-back arbiter driving the four write ports of the 128-entry physical register file. Functional units present results (physical address, data) through per-source valid/ready handshakes. The block buffers them in per-source FIFOs and issues up to NR_WB_PORTS register writes per cycle. It guarantees that no two ports write the same address in one cycle, and it discards writes to hardwired-zero register 127.

---
 rtl/regfile_wb_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: per-source result FIFOs feeding NR_WB_PORTS register-file write ports,
// round-robin start point, no duplicate addresses per cycle, writes to register 127 dropped.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH  = 64,
    parameter int NR_WB_PORTS = 4,
    parameter int NR_SRC      = 6,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_i,
    input  logic [NR_SRC-1:0]                      src_valid_i,
    output logic [NR_SRC-1:0]                      src_ready_o,
    input  logic [NR_SRC-1:0][6:0]                 src_waddr_i,
    input  logic [NR_SRC-1:0][DATA_WIDTH-1:0]      src_wdata_i,
    output logic [NR_WB_PORTS-1:0]                 we_a_o,
    output logic [NR_WB_PORTS-1:0][6:0]            waddr_a_o,
    output logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0] wdata_a_o
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SRC_W  = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int PORT_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;
    localparam logic [6:0] ZERO_REG = 7'd127;

    logic [6:0]            fifo_addr_q [NR_SRC][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [NR_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]      rptr_q [NR_SRC];
    logic [PTR_W-1:0]      wptr_q [NR_SRC];
    logic [CNT_W-1:0]      cnt_q  [NR_SRC];
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [6:0]            head_addr [NR_SRC];
    logic [DATA_WIDTH-1:0] head_data [NR_SRC];
    logic [NR_SRC-1:0]     nonempty, grant, push;

    logic [NR_WB_PORTS-1:0]                 we_d;
    logic [NR_WB_PORTS-1:0][6:0]            waddr_d;
    logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0] wdata_d;

    logic [PORT_W:0] n_grant;
    logic [SRC_W:0]  visit_sum;
    logic [SRC_W-1:0] visit_idx;
    logic            conflict;

    // Ready comes from registered occupancy only, so a full FIFO stays not-ready even while popping.
    always_comb begin
        for (int s = 0; s < NR_SRC; s++) begin
            src_ready_o[s] = (cnt_q[s] != CNT_W'(FIFO_DEPTH)) && !rst;
            push[s]        = src_valid_i[s] && src_ready_o[s] && !flush_i &&
                             (src_waddr_i[s] != ZERO_REG);
            nonempty[s]    = (cnt_q[s] != '0);
            head_addr[s]   = fifo_addr_q[s][rptr_q[s]];
            head_data[s]   = fifo_data_q[s][rptr_q[s]];
        end
    end

    always_comb begin
        grant     = '0;
        we_d      = '0;
        waddr_d   = '0;
        wdata_d   = '0;
        rr_ptr_d  = rr_ptr_q;
        n_grant   = '0;
        visit_sum = '0;
        visit_idx = '0;
        conflict  = 1'b0;
        for (int i = 0; i < NR_SRC; i++) begin
            visit_sum = {1'b0, rr_ptr_q} + (SRC_W + 1)'(i);
            if (visit_sum >= (SRC_W + 1)'(NR_SRC))
                visit_sum = visit_sum - (SRC_W + 1)'(NR_SRC);
            visit_idx = visit_sum[SRC_W-1:0];
            // A head whose address is already granted this cycle waits; later sources may still go.
            conflict = 1'b0;
            for (int p = 0; p < NR_WB_PORTS; p++)
                if (we_d[p] && (waddr_d[p] == head_addr[visit_idx]))
                    conflict = 1'b1;
            if (nonempty[visit_idx] && !conflict &&
                (n_grant < (PORT_W + 1)'(NR_WB_PORTS))) begin
                grant[visit_idx]              = 1'b1;
                we_d[n_grant[PORT_W-1:0]]     = 1'b1;
                waddr_d[n_grant[PORT_W-1:0]]  = head_addr[visit_idx];
                wdata_d[n_grant[PORT_W-1:0]]  = head_data[visit_idx];
                rr_ptr_d = (visit_idx == SRC_W'(NR_SRC - 1)) ? '0 : visit_idx + SRC_W'(1);
                n_grant  = n_grant + (PORT_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            we_a_o    <= '0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
            for (int s = 0; s < NR_SRC; s++) begin
                rptr_q[s] <= '0;
                wptr_q[s] <= '0;
                cnt_q[s]  <= '0;
            end
        end else begin
            we_a_o    <= flush_i ? '0 : we_d;
            waddr_a_o <= flush_i ? '0 : waddr_d;
            wdata_a_o <= flush_i ? '0 : wdata_d;
            if (!flush_i)
                rr_ptr_q <= rr_ptr_d;
            for (int s = 0; s < NR_SRC; s++) begin
                if (flush_i) begin
                    rptr_q[s] <= '0;
                    wptr_q[s] <= '0;
                    cnt_q[s]  <= '0;
                end else begin
                    if (grant[s])
                        rptr_q[s] <= rptr_q[s] + PTR_W'(1);
                    if (push[s])
                        wptr_q[s] <= wptr_q[s] + PTR_W'(1);
                    case ({push[s], grant[s]})
                        2'b10:   cnt_q[s] <= cnt_q[s] + CNT_W'(1);
                        2'b01:   cnt_q[s] <= cnt_q[s] - CNT_W'(1);
                        default: cnt_q[s] <= cnt_q[s];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NR_SRC; s++) begin
            if (push[s]) begin
                fifo_addr_q[s][wptr_q[s]] <= src_waddr_i[s];
                fifo_data_q[s][wptr_q[s]] <= src_wdata_i[s];
            end
        end
    end

endmodule
